// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, single-outstanding instruction fetch and IF/ID register.
// A response that arrives while IF/ID is stalled is parked in hold_inst so it
// is never refetched; a redirect discards whatever is in flight or parked.
module fetch_stage #(
  parameter int                    PC_WIDTH   = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pc_write,
  input  logic                  IF_ID_write,
  input  logic                  IF_ID_flush,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]   IF_ID_pc,
  output logic [INST_WIDTH-1:0] IF_ID_inst,
  output logic                  IF_ID_valid
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0] hold_inst_q, hold_inst_d;
  logic [PC_WIDTH-1:0]   if_id_pc_q, if_id_pc_d;
  logic [INST_WIDTH-1:0] if_id_inst_q, if_id_inst_d;
  logic                  if_id_valid_q, if_id_valid_d;

  logic                  adv;
  logic                  have_inst;
  logic [INST_WIDTH-1:0] avail_inst;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [PC_WIDTH-1:0]   redir_tgt;

  assign adv       = pc_write & IF_ID_write & ~IF_ID_flush;
  assign pc_inc    = pc_q + PC_WIDTH'(4);
  assign redir_tgt = {redirect_pc[PC_WIDTH-1:2], 2'b00};

  assign IF_ID_pc    = if_id_pc_q;
  assign IF_ID_inst  = if_id_inst_q;
  assign IF_ID_valid = if_id_valid_q;

  // Next-state, PC, hold buffer, IF/ID load and memory request generation
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_inst_d   = hold_inst_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_valid_d = if_id_valid_q;
    imem_req      = 1'b0;
    imem_addr     = pc_q;
    have_inst     = 1'b0;
    avail_inst    = hold_inst_q;

    case (state_q)
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          have_inst  = 1'b1;
          avail_inst = imem_rdata;
          if (adv) begin
            pc_d = pc_inc;
            // Back-to-back issue of the next word, unless a redirect is
            // about to make it stale.
            if (!redirect_valid) begin
              imem_req  = 1'b1;
              imem_addr = pc_inc;
            end
            state_d = imem_ready ? S_WAIT : S_REQ;
          end else begin
            hold_inst_d = imem_rdata;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        have_inst = 1'b1;
        if (adv) begin
          pc_d    = pc_inc;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // IF/ID: kill beats load, load beats bubble, bubble beats hold
    if (redirect_valid || IF_ID_flush) begin
      if_id_pc_d    = pc_q;
      if_id_inst_d  = NOP_INST;
      if_id_valid_d = 1'b0;
    end else if (adv && have_inst) begin
      if_id_pc_d    = pc_q;
      if_id_inst_d  = avail_inst;
      if_id_valid_d = 1'b1;
    end else if (IF_ID_write) begin
      if_id_pc_d    = pc_q;
      if_id_inst_d  = NOP_INST;
      if_id_valid_d = 1'b0;
    end

    // Redirect overrides everything; a request still in flight must be drained
    if (redirect_valid) begin
      pc_d        = redir_tgt;
      hold_inst_d = NOP_INST;
      if ((state_q == S_WAIT && !imem_rvalid) ||
          (state_q == S_REQ  &&  imem_ready)  ||
          (state_q == S_DROP && !imem_rvalid))
        state_d = S_DROP;
      else
        state_d = S_REQ;
    end
  end

  // State, PC, hold buffer and IF/ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      hold_inst_q   <= NOP_INST;
      if_id_pc_q    <= RESET_PC;
      if_id_inst_q  <= NOP_INST;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_inst_q   <= hold_inst_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: memory model returns address-as-data with selectable latency;
// every newly loaded valid IF/ID entry is checked against an in-order queue of
// expected fetch PCs.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b1, IF_ID_write = 1'b1, IF_ID_flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] IF_ID_pc, IF_ID_inst;
  logic        IF_ID_valid;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];
  logic        mon_en = 1'b1;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(mem_rvalid), .imem_rdata(mem_rdata),
    .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst), .IF_ID_valid(IF_ID_valid)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: data = address, response mem_lat+1 cycles after accept
  int          mem_lat = 0;
  int          mem_cnt;
  logic        mem_pend;
  logic [31:0] mem_paddr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      mem_pend   <= 1'b0;
      mem_cnt    <= 0;
      mem_paddr  <= '0;
    end else begin
      mem_rvalid <= 1'b0;
      if (mem_pend) begin
        if (mem_cnt == 0) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= mem_paddr;
          mem_pend   <= 1'b0;
        end else mem_cnt <= mem_cnt - 1;
      end
      if (imem_req && imem_ready) begin
        chk("one_outstanding", {31'b0, mem_pend}, 32'd0);
        if (mem_lat == 0) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= imem_addr;
        end else begin
          mem_pend  <= 1'b1;
          mem_cnt   <= mem_lat - 1;
          mem_paddr <= imem_addr;
        end
      end
    end
  end

  // Scoreboard: each valid entry freshly loaded into IF/ID is popped and compared
  logic loaded;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) loaded <= 1'b0;
    else        loaded <= IF_ID_write;
  end

  always @(negedge clk) begin
    if (mon_en && rst_n && loaded && IF_ID_valid) begin
      if (sb_q.size() == 0) chk("sb_unexpected_valid", {31'b0, IF_ID_valid}, 32'd0);
      else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        chk("sb_pc", IF_ID_pc, e);
        chk("sb_inst", IF_ID_inst, e);
      end
    end
  end

  initial begin
    int t;
    for (int a = 0; a < 32'h20; a += 4) sb_q.push_back(32'(a));

    // Reset state
    repeat (3) step();
    chk("rst_valid", {31'b0, IF_ID_valid}, 32'd0);
    chk("rst_pc", IF_ID_pc, 32'h0);
    chk("rst_inst", IF_ID_inst, NOP);
    rst_n = 1'b1;
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    step();
    chk("valid_edge1", {31'b0, IF_ID_valid}, 32'd0);
    step();
    chk("valid_edge2", {31'b0, IF_ID_valid}, 32'd1);

    // Load-use stall while the response for 0x8 arrives
    t = 0;
    while (!(mem_rvalid && mem_rdata == 32'h8) && t < 50) begin step(); t++; end
    chk("to_resp8", {31'b0, t < 50}, 32'd1);
    pc_write = 1'b0; IF_ID_write = 1'b0; IF_ID_flush = 1'b1;
    step();
    pc_write = 1'b1; IF_ID_write = 1'b1; IF_ID_flush = 1'b0;
    chk("lu_bubble", {31'b0, IF_ID_valid}, 32'd0);
    chk("lu_no_req", {31'b0, imem_req}, 32'd0);

    // Memory not ready for 3 cycles on the 0x10 request
    t = 0;
    while (!(imem_req && imem_addr == 32'h10) && t < 50) begin step(); t++; end
    chk("to_req10", {31'b0, t < 50}, 32'd1);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("nr_req", {31'b0, imem_req}, 32'd1);
      chk("nr_addr", imem_addr, 32'h10);
      if (i == 2) chk("nr_bubble", {31'b0, IF_ID_valid}, 32'd0);
      step();
    end
    chk("nr_bubble2", {31'b0, IF_ID_valid}, 32'd0);
    imem_ready = 1'b1;

    // Redirect (combined with a stall) while waiting on 0x20
    t = 0;
    while (!(imem_req && imem_addr == 32'h20) && t < 50) begin step(); t++; end
    chk("to_req20", {31'b0, t < 50}, 32'd1);
    mem_lat = 2;
    step();
    chk("wait_no_req", {31'b0, imem_req}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0101;
    pc_write = 1'b0; IF_ID_write = 1'b0;
    for (int a = 32'h100; a < 32'h110; a += 4) sb_q.push_back(32'(a));
    step();
    redirect_valid = 1'b0; pc_write = 1'b1; IF_ID_write = 1'b1; mem_lat = 0;
    chk("rd_bubble", {31'b0, IF_ID_valid}, 32'd0);
    chk("rd_bubble_inst", IF_ID_inst, NOP);
    chk("drop_no_req", {31'b0, imem_req}, 32'd0);
    t = 0;
    while (!imem_req && t < 20) begin step(); t++; end
    chk("to_req100", {31'b0, t < 20}, 32'd1);
    chk("rd_addr", imem_addr, 32'h100);

    // Redirect to the top of the address space, then wrap
    t = 0;
    while (!(IF_ID_valid && IF_ID_pc == 32'h10C) && t < 50) begin step(); t++; end
    chk("to_pc10c", {31'b0, t < 50}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #0;
    chk("rd2_no_req", {31'b0, imem_req}, 32'd0);
    sb_q.push_back(32'hFFFF_FFFC);
    for (int a = 0; a < 12; a += 4) sb_q.push_back(32'(a));
    step();
    redirect_valid = 1'b0;
    chk("rd2_req", {31'b0, imem_req}, 32'd1);
    chk("rd2_addr", imem_addr, 32'hFFFF_FFFC);
    chk("rd2_bubble", {31'b0, IF_ID_valid}, 32'd0);
    t = 0;
    while (!(imem_req && imem_addr != 32'hFFFF_FFFC) && t < 20) begin step(); t++; end
    chk("to_wrap", {31'b0, t < 20}, 32'd1);
    chk("wrap_addr", imem_addr, 32'h0);

    t = 0;
    while (sb_q.size() != 0 && t < 50) begin step(); t++; end
    chk("sb_drained", sb_q.size(), 32'd0);
    mon_en = 1'b0;
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
